// File: rtl/sb_pattern_detect.sv
// Receive-side SBINIT clock-pattern detector: counts consecutive matching deserialized
// sideband words, pulses samp_done on lock or time_out when the detection window expires.
module sb_pattern_detect #(
    parameter logic [63:0] PATTERN     = 64'hAAAA_AAAA_AAAA_AAAA,
    parameter int          REQ_MATCHES = 4,
    parameter int          CLKS_PER_MS = 100,
    parameter int          TIMEOUT_MS  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start_detect_req,
    input  logic [63:0] i_deser_data,
    input  logic        i_deser_valid,
    output logic        o_rx_sb_pattern_samp_done,
    output logic        o_pattern_time_out,
    output logic        o_busy,
    output logic [3:0]  o_match_cnt
);

    localparam int MS_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int EL_W = $clog2(TIMEOUT_MS) + 1;

    localparam logic [3:0]      REQ_FULL = 4'(REQ_MATCHES);
    localparam logic [3:0]      REQ_M1   = 4'(REQ_MATCHES - 1);
    localparam logic [MS_W-1:0] MS_LAST  = MS_W'(CLKS_PER_MS - 1);
    localparam logic [EL_W-1:0] EL_LAST  = EL_W'(TIMEOUT_MS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DETECT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state,      state_nx;
    logic [3:0]      match_cnt,  match_cnt_nx;
    logic [MS_W-1:0] ms_cnt,     ms_cnt_nx;
    logic [EL_W-1:0] ms_elapsed, ms_elapsed_nx;
    logic            samp_done,  samp_done_nx;
    logic            time_out,   time_out_nx;

    logic word_match;
    logic lock_hit;
    logic window_end;

    // Match count never runs past the lock threshold.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        sat_inc = (cnt >= REQ_FULL) ? REQ_FULL : cnt + 4'd1;
    endfunction

    // Inverted pattern is accepted to tolerate a one-UI phase offset.
    assign word_match = i_deser_valid &&
                        ((i_deser_data == PATTERN) || (i_deser_data == ~PATTERN));
    assign lock_hit   = word_match && (match_cnt == REQ_M1);
    assign window_end = (ms_cnt == MS_LAST) && (ms_elapsed == EL_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            match_cnt  <= '0;
            ms_cnt     <= '0;
            ms_elapsed <= '0;
            samp_done  <= 1'b0;
            time_out   <= 1'b0;
        end else begin
            state      <= state_nx;
            match_cnt  <= match_cnt_nx;
            ms_cnt     <= ms_cnt_nx;
            ms_elapsed <= ms_elapsed_nx;
            samp_done  <= samp_done_nx;
            time_out   <= time_out_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        match_cnt_nx  = match_cnt;
        ms_cnt_nx     = ms_cnt;
        ms_elapsed_nx = ms_elapsed;
        samp_done_nx  = 1'b0;
        time_out_nx   = 1'b0;

        case (state)
            IDLE: begin
                match_cnt_nx  = '0;
                ms_cnt_nx     = '0;
                ms_elapsed_nx = '0;
                if (i_start_detect_req) begin
                    state_nx = DETECT;
                end
            end

            DETECT: begin
                if (!i_start_detect_req) begin
                    // Abort outranks both lock and timeout.
                    state_nx      = IDLE;
                    match_cnt_nx  = '0;
                    ms_cnt_nx     = '0;
                    ms_elapsed_nx = '0;
                end else begin
                    if (ms_cnt == MS_LAST) begin
                        ms_cnt_nx     = '0;
                        ms_elapsed_nx = ms_elapsed + EL_W'(1);
                    end else begin
                        ms_cnt_nx = ms_cnt + MS_W'(1);
                    end

                    if (word_match) begin
                        match_cnt_nx = sat_inc(match_cnt);
                    end else if (i_deser_valid) begin
                        match_cnt_nx = '0;
                    end

                    if (lock_hit) begin
                        match_cnt_nx = REQ_FULL;
                        samp_done_nx = 1'b1;
                        state_nx     = HOLD;
                    end else if (window_end) begin
                        time_out_nx = 1'b1;
                        state_nx    = HOLD;
                    end
                end
            end

            HOLD: begin
                if (!i_start_detect_req) begin
                    state_nx      = IDLE;
                    match_cnt_nx  = '0;
                    ms_cnt_nx     = '0;
                    ms_elapsed_nx = '0;
                end
            end

            default: begin
                state_nx      = IDLE;
                match_cnt_nx  = '0;
                ms_cnt_nx     = '0;
                ms_elapsed_nx = '0;
            end
        endcase
    end

    assign o_rx_sb_pattern_samp_done = samp_done;
    assign o_pattern_time_out        = time_out;
    assign o_busy                    = (state == DETECT);
    assign o_match_cnt               = match_cnt;

endmodule
